// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through read,
// registered occupancy flags, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_param #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4,
  parameter int FWFT      = 0,
  parameter int AF_LEVEL  = (1 << ADDR_SIZE) - 2,
  parameter int AE_LEVEL  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 wr_en,
  input  logic [DATA_SIZE-1:0] din,
  input  logic                 rd_en,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 dout_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 err_clr
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] CNT_ONE   = {{ADDR_SIZE{1'b0}}, 1'b1};
  localparam logic [ADDR_SIZE:0] CNT_DEPTH = {1'b1, {ADDR_SIZE{1'b0}}};
  localparam logic [ADDR_SIZE:0] AF_CNT    = AF_LEVEL[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0] AE_CNT    = AE_LEVEL[ADDR_SIZE:0];

  if (AF_LEVEL <= 0 || AF_LEVEL > DEPTH) begin : g_bad_af_level
    $error("sync_fifo_param: AF_LEVEL must satisfy 0 < AF_LEVEL <= DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_bad_ae_level
    $error("sync_fifo_param: AE_LEVEL must satisfy 0 <= AE_LEVEL < DEPTH");
  end

  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  logic [ADDR_SIZE:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_SIZE:0]   count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 almost_full_q, almost_full_d;
  logic                 almost_empty_q, almost_empty_d;
  logic [DATA_SIZE-1:0] dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic                 wr_acc, rd_acc, mem_we;
  logic [DATA_SIZE-1:0] head_word;

  assign head_word = mem_q[rd_ptr_q[ADDR_SIZE-1:0]];

  always_comb begin
    wr_acc         = wr_en & ~full_q & ~flush;
    rd_acc         = rd_en & ~empty_q & ~flush;
    mem_we         = wr_acc & reset;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    dout_d         = dout_q;
    dout_valid_d   = 1'b0;
    overflow_d     = overflow_q;
    underflow_d    = underflow_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + CNT_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + CNT_ONE;
      if (wr_acc && !rd_acc) count_d = count_q + CNT_ONE;
      if (rd_acc && !wr_acc) count_d = count_q - CNT_ONE;
      if (rd_acc && FWFT == 0) begin
        dout_d       = head_word;
        dout_valid_d = 1'b1;
      end
    end

    // Clear first so that a same-cycle error event wins over err_clr.
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && full_q && !flush)  overflow_d  = 1'b1;
    if (rd_en && empty_q && !flush) underflow_d = 1'b1;

    full_d         = (count_d == CNT_DEPTH);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= AF_CNT);
    almost_empty_d = (count_d <= AE_CNT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      dout_q         <= '0;
      dout_valid_q   <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      dout_q         <= dout_d;
      dout_valid_q   <= dout_valid_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q[ADDR_SIZE-1:0]] <= din;
  end

  // In FWFT mode the head word is presented combinationally from the array.
  always_comb begin
    if (FWFT != 0) begin
      dout       = empty_q ? '0 : head_word;
      dout_valid = ~empty_q;
    end else begin
      dout       = dout_q;
      dout_valid = dout_valid_q;
    end
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised successor to the dual-clock pointer FIFO.
- Adds explicit write/read handshakes, a selectable read mode (standard or first-word-fall-through), an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags.
- Sits between a data producer (e.g. ROM fetch path) and a consumer in the same clock domain, so no gray-code synchronisers are needed.

Parameters:
DATA_SIZE, 8, data word width in bits
ADDR_SIZE, 4, address width; DEPTH = 1<<ADDR_SIZE words
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL
AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL

Ports:
clk  in  1  single clock; all state updates on posedge clk
reset  in  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
flush  in  1  synchronous clear of pointers and count
wr_en  in  1  write request
din  in  DATA_SIZE  write data
rd_en  in  1  read request (pop in FWFT mode)
dout  out  DATA_SIZE  read data
dout_valid  out  1  dout holds a freshly read word (standard mode) / head word valid (FWFT)
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  ADDR_SIZE+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
err_clr  in  1  clears overflow/underflow

Behaviour:
- Pointers wr_ptr and rd_ptr are ADDR_SIZE+1 bits wide. Memory is indexed by the low ADDR_SIZE bits; the MSB is the wrap bit. Pointers wrap modulo 2*DEPTH.
- Reset (reset==0 at posedge) values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, dout=0, dout_valid=0, overflow=0, underflow=0. Memory contents are not cleared.
- Reset mid-operation discards all stored words. Reset has priority over flush, wr_en and rd_en.
- wr_acc = wr_en & ~full. rd_acc = rd_en & ~empty. Both are evaluated on pre-edge flags.
- On wr_acc, mem[wr_ptr] <= din and wr_ptr increments.
- On rd_acc, rd_ptr increments.
- count changes by +1 on wr_acc only, −1 on rd_acc only, and is unchanged when both or neither are accepted.
- Simultaneous wr_en and rd_en:
  - When full: the read is accepted, the write is rejected, and overflow is set.
  - When empty: the write is accepted, the read is rejected, and underflow is set.
- Flags (full, empty, almost_*) are registered. They reflect the count after the edge, i.e. they update in the same cycle as count, with 1-cycle latency from the request.
- Standard mode (FWFT=0):
  - On rd_acc, dout <= mem[rd_ptr] and dout_valid <= 1 in the next cycle.
  - When there is no rd_acc, dout_valid <= 0 and dout holds its value.
  - Read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr[ADDR_SIZE-1:0]] whenever empty==0, and dout_valid = ~empty.
  - rd_en consumes the displayed word.
  - A write into an empty FIFO is visible on dout in the cycle after the write edge.
- flush==1 (with reset high):
  - wr_ptr=rd_ptr=0, count=0, empty=1, full=0, dout_valid=0.
  - wr_en and rd_en in the same cycle are ignored and raise no error flags.
  - overflow and underflow are preserved.
- overflow <= 1 when wr_en & full & ~flush. underflow <= 1 when rd_en & empty & ~flush.
- err_clr clears both flags. If set and clear occur in the same cycle, set wins.
- Parameter legality (elaboration check): 0 < AF_LEVEL <= DEPTH and 0 <= AE_LEVEL < DEPTH.

Test Plan:
- Reset/basic order: hold reset=0 for 2 clks, then write 0,4,8,…,60 (16 words) with rd_en=0.
  - full=1 and count=16 after the 16th edge; almost_full rises at count=14.
  - Reading 16 words (FWFT=0) returns 0,4,…,60, each 1 cycle after its rd_en; empty=1 after the last read.
- Overflow/underflow: with the FIFO full, assert wr_en for 1 cycle with din=0xAA.
  - overflow=1, count stays 16, and 0xAA is never read back.
  - Draining, then rd_en on the empty FIFO sets underflow=1.
  - err_clr for 1 cycle clears both flags.
- Simultaneous operations:
  - At count=5, wr_en=rd_en=1 for 10 cycles: count stays 5 throughout and data order is preserved.
  - With full, wr_en=rd_en=1: count goes to 15 and overflow=1.
- Wrap-around: write/read 40 words continuously, rd_en lagging by 3 cycles.
  - Read sequence equals write sequence across 2+ pointer wraps.
  - count never exceeds 4, and neither full nor overflow asserts.
- FWFT=1 instance: write 0x11 into the empty FIFO.
  - dout=0x11 and dout_valid=1 on the next cycle with no rd_en.
  - rd_en for 1 cycle makes empty=1 and dout_valid=0.
- Flush and mid-operation reset:
  - At count=9 with overflow=1, pulse flush with wr_en=1: count=0, empty=1, overflow still 1, and the write is discarded.
  - At count=7, reset=0 for 1 clk: every output returns to its reset value.
